// File: rtl/l0_loader.sv
// ---------------------------------------------------------------------------
// l0_loader
//
// Streams a contiguous block of words from a single-port SRAM into the L0
// FIFO. A load is requested with a one-cycle start pulse carrying a base
// address and a word count. Reads are issued one per cycle to the SRAM. Each
// returned word lands in a 2-entry holding buffer and is forwarded to L0
// whenever L0 has room. The number of words buffered or in flight is capped
// at two, so L0 back-pressure throttles the SRAM reads without losing data.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high reset; aborts any load in progress
//   start      : one-cycle load request, honoured only while idle
//   base_addr  : first SRAM word address of the load (latched with start)
//   len        : number of words to move, 0..2^ADDR_W (latched with start)
//   I_A        : SRAM word address
//   I_CEN      : SRAM chip enable, active-low
//   I_WEN      : SRAM write enable, active-low (held high, read-only user)
//   I_Q        : SRAM read data, valid the cycle after an I_CEN=0 cycle
//   l0_full    : L0 cannot accept a word this cycle
//   l0_wr      : L0 write strobe
//   l0_in      : L0 write data, valid with l0_wr
//   busy       : high whenever a load is in progress (any state but IDLE)
//   done       : one-cycle pulse when a load completes
// ---------------------------------------------------------------------------
module l0_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] I_A,
  output logic              I_CEN,
  output logic              I_WEN,
  input  logic [DATA_W-1:0] I_Q,
  input  logic              l0_full,
  output logic              l0_wr,
  output logic [DATA_W-1:0] l0_in,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Load descriptor latched on an accepted start.
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;

  // Progress counters: reads issued to SRAM, words written into L0.
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W:0]   r_written;

  // A read was issued last cycle, so I_Q carries a word this cycle.
  logic              r_inflight;

  // Last address driven, so I_A stays steady on idle SRAM cycles.
  logic [ADDR_W-1:0] r_a_hold;

  // 2-entry holding buffer bookkeeping.
  logic [1:0]        r_occ;
  logic              r_wr_ptr;
  logic              r_rd_ptr;

  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_committed;
  logic [1:0]        w_occ_next;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   w_issued_next;
  logic [ADDR_W:0]   w_written_next;
  logic [DATA_W-1:0] w_head;
  logic              w_accept;

  // -------------------------------------------------------------------------
  // Holding buffer storage: one register per entry, written when the
  // returning SRAM word targets that slot.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      logic [DATA_W-1:0] r_entry;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_entry <= '0;
        end else if (w_push && (r_wr_ptr == 1'(gi))) begin
          r_entry <= I_Q;
        end
      end
    end
  endgenerate

  assign w_head = r_rd_ptr ? g_buf[1].r_entry : g_buf[0].r_entry;

  // -------------------------------------------------------------------------
  // Datapath control
  // -------------------------------------------------------------------------
  // The word returning this cycle is exactly the one issued last cycle.
  assign w_push = r_inflight;
  assign w_pop  = (r_occ != 2'd0) && !l0_full;

  // Words that will still be held after this cycle (buffered + arriving -
  // leaving). Keeping this below two before issuing guarantees the buffer
  // has a free slot for the word that will come back next cycle.
  assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_issue = (r_state == S_READ) && (w_committed < 3'd2) &&
                   (r_issued < r_len);

  // Truncation to ADDR_W bits gives the wrap from the top address to 0.
  assign w_addr = r_base + r_issued[ADDR_W-1:0];

  assign w_issued_next  = r_issued  + {{ADDR_W{1'b0}}, w_issue};
  assign w_written_next = r_written + {{ADDR_W{1'b0}}, w_pop};
  assign w_occ_next     = r_occ + {1'b0, w_push} - {1'b0, w_pop};

  assign w_accept = (r_state == S_IDLE) && start;

  // -------------------------------------------------------------------------
  // FSM next state and state-derived outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (w_issued_next == r_len) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Look ahead one cycle so that done lands in the cycle right after
        // the final L0 write.
        if ((w_written_next == r_len) && (w_occ_next == 2'd0)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // SRAM and L0 interface outputs.
  always_comb begin
    I_CEN = ~w_issue;
    I_WEN = 1'b1;
    I_A   = w_issue ? w_addr : r_a_hold;
    l0_wr = w_pop;
    l0_in = w_pop ? w_head : '0;
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_written  <= '0;
      r_inflight <= 1'b0;
      r_a_hold   <= '0;
      r_occ      <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      r_occ      <= w_occ_next;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_issue) begin
        r_a_hold <= w_addr;
      end
      if (w_accept) begin
        r_base    <= base_addr;
        r_len     <= len;
        r_issued  <= '0;
        r_written <= '0;
      end else begin
        r_issued  <= w_issued_next;
        r_written <= w_written_next;
      end
    end
  end

endmodule

// File: doc/l0_loader.md
L0_LOADER -- requirements
Module: l0_loader

Interface
REQ-001 Parameter ADDR_W, default 7, SRAM word-address width.
REQ-002 Parameter DATA_W, default 32, SRAM/L0 word width (8 lanes x bw=4).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first SRAM address of the load; latched with start.
REQ-007 len  input  ADDR_W+1  number of words to transfer, 0..128; latched with start.
REQ-008 I_A  output  ADDR_W  SRAM address.
REQ-009 I_CEN  output  1  SRAM chip enable, active-low.
REQ-010 I_WEN  output  1  SRAM write enable, active-low; this block only reads.
REQ-011 I_Q  input  DATA_W  SRAM read data, valid the cycle after an I_CEN=0 cycle.
REQ-012 l0_full  input  1  L0 FIFO cannot accept a word this cycle.
REQ-013 l0_wr  output  1  L0 write strobe.
REQ-014 l0_in  output  DATA_W  L0 write data, valid when l0_wr=1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at load completion.

Function
REQ-017 FSM states IDLE, READ, DRAIN, DONE; IDLE->READ on start with len>0; IDLE->DONE on start with len=0.
REQ-018 READ: issue read when issue_ok; address = base_addr + issued count, modulo 2^ADDR_W (127 wraps to 0).
REQ-019 issue_ok = (buffer occupancy + reads in flight - pop this cycle) < 2 and issued count < len.
REQ-020 Issued read cycle: I_CEN=0, I_A=address; otherwise I_CEN=1 and I_A holds its last value.
REQ-021 I_WEN SHALL be 1 in every cycle.
REQ-022 Data return: I_Q captured into a 2-entry FIFO holding buffer at the end of the cycle after issue; no word is ever dropped or duplicated.
REQ-023 Pop: l0_wr=1 and l0_in=buffer head whenever buffer non-empty and l0_full=0; l0_wr SHALL never be 1 while l0_full=1.
REQ-024 READ->DRAIN when issued count reaches len; DRAIN->DONE when buffer empty, no read in flight, and all len words written.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 Throughput with l0_full=0: one word per cycle; start high in cycle 0 -> first I_CEN=0 cycle 1 (I_A=base_addr), first l0_wr cycle 3, last l0_wr cycle len+2, done cycle len+3.
REQ-027 Words reach L0 in ascending address order (with wrap), exactly len writes per load.
REQ-028 start while busy SHALL be ignored, no effect on latched base_addr/len.
REQ-029 l0_full asserted mid-load: issuing stalls within the buffer limit; resumes without loss when deasserted.
REQ-030 len=0: no SRAM access, no l0_wr, done pulse in cycle 1.

Reset
REQ-031 reset=1: state IDLE, buffer and in-flight tracking cleared, counters zero.
REQ-032 Reset output values: I_CEN=1, I_WEN=1, I_A=0, l0_wr=0, l0_in=0, busy=0, done=0.
REQ-033 Reset mid-load aborts; SRAM data returned in the cycle after reset is discarded; no done pulse.

Verification
REQ-034 base_addr=0x10, len=4, l0_full=0 -> I_A 0x10..0x13 cycles 1-4, l0_wr cycles 3-6 with SRAM data 0x10..0x13 in order, done cycle 7.
REQ-035 base_addr=0x7E, len=4 -> I_A sequence 0x7E,0x7F,0x00,0x01; four L0 words in that order.
REQ-036 len=8, l0_full high cycles 4-9 -> no l0_wr while full, I_CEN=0 in at most 2 cycles outstanding beyond pops, all 8 words delivered in order, exactly one done.
REQ-037 len=0 -> I_CEN stays 1, no l0_wr, done=1 cycle 1, busy=1 cycle 1 only.
REQ-038 len=16, reset asserted cycle 6 for one cycle -> all outputs at reset values next cycle, no further l0_wr, no done; new start with len=2 completes normally.
REQ-039 start pulsed again at cycle 3 of a len=6 load -> ignored; exactly 6 writes, single done.
